pb_scan_ctrl: RTL and testbench
===============================

// Module: pb_scan_ctrl
// PURPOSE
//  Time-multiplexed debounce scheduler for NBTN push-buttons sharing one debounce/compare engine.
//  On each 1 ms tick the FSM walks the buttons once, one button per clk cycle:
//  - shift the synchronized raw sample into that button's history
//  - update its debounced level (pbreg)
//  - emit press/release/auto-repeat pulses
//  Sits between board button pins and the Lab5 CPU/IO logic; replaces per-button pbdebounce copies.
// PARAMETERS
//  NBTN        4   number of buttons scanned (1..16)
//  SAMPLES     4   history depth; level changes only after SAMPLES equal consecutive samples (2..8)
//  HOLD_W      10  width of per-button hold counter (ticks)
//  LONG_TICKS  500 ticks held before first repeat pulse; 0 disables repeat
//  REP_TICKS   100 ticks between subsequent repeat pulses; must be 1..LONG_TICKS
// PORTS
//  clk       in   1     system clock, all logic rising-edge
//  rst       in   1     asynchronous, active-high reset
//  tick_1ms  in   1     one-clk-wide scan request, nominally every 1 ms
//  button    in   NBTN  raw asynchronous button inputs, 1 = pressed
//  pbreg     out  NBTN  debounced level per button
//  press     out  NBTN  1-clk pulse on debounced 0->1
//  release   out  NBTN  1-clk pulse on debounced 1->0
//  repeat    out  NBTN  1-clk auto-repeat pulse while held
//  busy      out  1     high while scan in progress
//  overrun   out  1     sticky: tick arrived while busy; cleared only by rst
// BEHAVIOUR
//  Reset: async; all outputs 0; histories 0; hold counters 0; FSM IDLE; scan index 0.
//  Input sync: button passes through a 2-flop synchronizer; only the synchronized value is sampled.
//  FSM states:
//  - IDLE: on tick_1ms go to SCAN with idx=0.
//  - SCAN: process button idx. If idx==NBTN-1 go to IDLE, else idx+1.
//  busy = (state==SCAN).
//  Latency: tick in cycle t -> button k processed in cycle t+1+k.
//  Its pbreg/press/release/repeat change at the clk edge ending that cycle.
//  Processing button k:
//  - hist[k] <= {hist[k][SAMPLES-2:0], sync[k]}.
//  - If the new history is all ones and pbreg[k]==0: pbreg[k]<=1, press[k] pulses.
//  - If the new history is all zeros and pbreg[k]==1: pbreg[k]<=0, release[k] pulses.
//  - Mixed history: pbreg[k] holds (bounce rejected).
//  Hold counter, per button, updated only in that button's SCAN slot:
//  - New level 0: cnt <= 0.
//  - New level 1 with LONG_TICKS!=0: cnt <= cnt+1, except
//    when cnt+1 == LONG_TICKS: repeat[k] pulses and cnt <= LONG_TICKS-REP_TICKS.
//  - So repeat fires at LONG, LONG+REP, LONG+2*REP ticks after the press slot; cnt never wraps.
//  - The press slot itself counts as cnt=1.
//  Pulse outputs are 0 in every cycle except the one following a triggering SCAN slot.
//  tick_1ms while busy: set overrun. Tick is not queued; the current scan completes normally.
//  tick_1ms in the same cycle as the last SCAN slot counts as busy: overrun set, no new scan.
//  tick_1ms during rst is ignored.
//  Reset mid-scan: everything returns to reset values immediately; no partial pulses are emitted.
// TESTING
//  1. rst pulse, then idle 20 ticks with button=0 -> pbreg=0, no pulses, busy high exactly NBTN clks per tick.
//  2. button[0]=1 steady, SAMPLES=4 -> press[0] single pulse in the slot of the 4th scan after sync; pbreg[0]=1.
//  3. button[1] toggles every tick for 10 ticks -> pbreg[1] stays 0; no press/release.
//  4. Hold button[2]; LONG=5, REP=2 -> repeat[2] on hold ticks 5,7,9.
//     Release -> release[2] after 4 zero scans; counter back to 0.
//  5. Two ticks 2 clks apart (NBTN=4) -> overrun=1, only one scan (busy 4 clks); overrun held until rst.
//  6. Assert rst mid-scan (idx=2) with pbreg=4'b1111 -> outputs 0 immediately; next tick scans from idx 0.

Source files
------------

// File: rtl/pb_scan_ctrl.sv
`default_nettype none
// pb_scan_ctrl: one shared debounce/hold engine time-multiplexed across NBTN push-buttons.
// Revision 1.0
module pb_scan_ctrl #(
  parameter int NBTN       = 4,
  parameter int SAMPLES    = 4,
  parameter int HOLD_W     = 10,
  parameter int LONG_TICKS = 500,
  parameter int REP_TICKS  = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1ms,
  input  logic [NBTN-1:0] button,
  output logic [NBTN-1:0] pbreg,
  output logic [NBTN-1:0] press,
  // release/repeat are reserved words, hence the _pulse suffix
  output logic [NBTN-1:0] release_pulse,
  output logic [NBTN-1:0] repeat_pulse,
  output logic            busy,
  output logic            overrun
);

  localparam int                IDX_W    = (NBTN > 1) ? $clog2(NBTN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBTN - 1);
  localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] RELOAD_C = HOLD_W'(LONG_TICKS - REP_TICKS);
  localparam logic [HOLD_W-1:0] ONE_C    = HOLD_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [NBTN-1:0]    sync1, sync2;
  logic [SAMPLES-1:0] hist [NBTN];
  logic [HOLD_W-1:0]  cnt  [NBTN];

  logic [SAMPLES-1:0] hist_new;
  logic               lvl_cur, lvl_new, rise, fall, rep_hit;
  logic [HOLD_W-1:0]  cnt_cur, cnt_inc, cnt_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (tick_1ms) begin
          state_nxt = S_SCAN;
          idx_nxt   = '0;
        end
      end
      S_SCAN: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == S_SCAN);

  // Shared engine: evaluates the button selected by idx only.
  always_comb begin
    hist_new = {hist[idx][SAMPLES-2:0], sync2[idx]};
    lvl_cur  = pbreg[idx];
    lvl_new  = lvl_cur;
    if (&hist_new) begin
      lvl_new = 1'b1;
    end else if (hist_new == '0) begin
      lvl_new = 1'b0;
    end
    rise    = lvl_new & ~lvl_cur;
    fall    = ~lvl_new & lvl_cur;
    cnt_cur = cnt[idx];
    cnt_inc = cnt_cur + ONE_C;
    cnt_new = '0;
    rep_hit = 1'b0;
    if (lvl_new && (LONG_TICKS != 0)) begin
      if (cnt_inc == LONG_C) begin
        rep_hit = 1'b1;
        cnt_new = RELOAD_C;
      end else begin
        cnt_new = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      pbreg         <= '0;
      press         <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      overrun       <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        hist[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      sync1         <= button;
      sync2         <= sync1;
      press         <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      if (tick_1ms && (state == S_SCAN)) begin
        overrun <= 1'b1;
      end
      if (state == S_SCAN) begin
        hist[idx]          <= hist_new;
        cnt[idx]           <= cnt_new;
        pbreg[idx]         <= lvl_new;
        press[idx]         <= rise;
        release_pulse[idx] <= fall;
        repeat_pulse[idx]  <= rep_hit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_scan_ctrl.sv
`default_nettype none
// tb_pb_scan_ctrl: directed + randomized bench for pb_scan_ctrl against a run-length/held-tick model.
module tb_pb_scan_ctrl;
  localparam int NBTN = 4, SAMPLES = 4, HOLD_W = 10, LONG = 5, REP = 2;

  logic            clk = 1'b0, rst = 1'b0, tick_1ms = 1'b0;
  logic [NBTN-1:0] button = '0;
  logic [NBTN-1:0] pbreg, press, release_pulse, repeat_pulse;
  logic            busy, overrun;

  int checks = 0, failures = 0;
  int run_val [NBTN];
  int run_len [NBTN];
  int lvl     [NBTN];
  int held    [NBTN];
  bit exp_ovr;

  always #5 clk = ~clk;

  pb_scan_ctrl #(
    .NBTN(NBTN), .SAMPLES(SAMPLES), .HOLD_W(HOLD_W), .LONG_TICKS(LONG), .REP_TICKS(REP)
  ) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .button(button),
    .pbreg(pbreg), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NBTN; k++) begin
      run_val[k] = 0;
      run_len[k] = SAMPLES;
      lvl[k]     = 0;
      held[k]    = 0;
    end
    exp_ovr = 1'b0;
  endtask

  // Level follows the input once the trailing run of equal samples reaches SAMPLES;
  // repeat fires at held ticks LONG, LONG+REP, LONG+2*REP, ...
  task automatic model_scan(input int k, input int s, output bit p, output bit r, output bit q);
    int old;
    if (s == run_val[k]) begin
      if (run_len[k] < SAMPLES) run_len[k]++;
    end else begin
      run_val[k] = s;
      run_len[k] = 1;
    end
    old = lvl[k];
    if (run_len[k] >= SAMPLES) lvl[k] = run_val[k];
    p = (old == 0) && (lvl[k] == 1);
    r = (old == 1) && (lvl[k] == 0);
    held[k] = (lvl[k] == 1) ? held[k] + 1 : 0;
    q = (lvl[k] == 1) && (held[k] >= LONG) && (((held[k] - LONG) % REP) == 0);
  endtask

  function automatic logic [NBTN-1:0] lvl_vec();
    logic [NBTN-1:0] v;
    for (int k = 0; k < NBTN; k++) v[k] = (lvl[k] != 0);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_pulses", {press, release_pulse, repeat_pulse}, '0);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  // One tick and its full scan; dbl>=0 injects a second tick in scan slot dbl.
  task automatic scan_tick(input int dbl);
    bit p, r, q;
    logic [NBTN-1:0] ep, er, eq;
    @(negedge clk);
    check("pre_tick_busy", busy, 1'b0);
    tick_1ms = 1'b1;
    @(negedge clk);
    tick_1ms = 1'b0;
    for (int k = 0; k < NBTN; k++) begin
      check("scan_busy", busy, 1'b1);
      tick_1ms = (k == dbl);
      if (k == dbl) exp_ovr = 1'b1;
      model_scan(k, int'(button[k]), p, r, q);
      ep = '0; er = '0; eq = '0;
      ep[k] = p; er[k] = r; eq[k] = q;
      @(negedge clk);
      tick_1ms = 1'b0;
      check("press", press, ep);
      check("release", release_pulse, er);
      check("repeat", repeat_pulse, eq);
      check("pbreg", pbreg, lvl_vec());
      check("overrun", overrun, exp_ovr);
    end
    check("scan_end_busy", busy, 1'b0);
    @(negedge clk);
    check("no_extra_scan", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pbreg", pbreg, '0);
    check("rst_pulses", {press, release_pulse, repeat_pulse}, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    model_reset();

    // Idle ticks with all buttons released
    repeat (20) begin idle(3); scan_tick(-1); end

    // Steady press on button 0
    button[0] = 1'b1;
    repeat (6) begin idle(3); scan_tick(-1); end
    check("btn0_level", pbreg[0], 1'b1);

    // Bouncing button 1
    repeat (10) begin button[1] = ~button[1]; idle(3); scan_tick(-1); end
    check("btn1_bounce", pbreg[1], 1'b0);
    button[1] = 1'b0;

    // Long hold on button 2, release, then hold again from a cleared counter
    button[2] = 1'b1;
    repeat (12) begin idle(3); scan_tick(-1); end
    button[2] = 1'b0;
    repeat (6) begin idle(3); scan_tick(-1); end
    button[2] = 1'b1;
    repeat (8) begin idle(3); scan_tick(-1); end

    // Overrun: second tick two clocks after the first, then in the last slot
    button = '0;
    idle(3); scan_tick(1);
    repeat (3) begin idle(3); scan_tick(-1); end
    scan_tick(NBTN - 1);
    idle(3);
    check("overrun_sticky", overrun, 1'b1);

    // Reset in the middle of a scan with every button held
    button = '1;
    repeat (5) begin idle(3); scan_tick(-1); end
    check("all_held", pbreg, 4'b1111);
    @(negedge clk); tick_1ms = 1'b1;
    @(negedge clk); tick_1ms = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1; tick_1ms = 1'b1;
    #1;
    check("midrst_pbreg", pbreg, '0);
    check("midrst_pulses", {press, release_pulse, repeat_pulse}, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    @(negedge clk); tick_1ms = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    check("post_rst_busy", busy, 1'b0);
    repeat (5) begin idle(3); scan_tick(-1); end

    // Randomized button activity, spacing and occasional overlapping ticks
    repeat (60) begin
      for (int k = 0; k < NBTN; k++)
        if ($urandom_range(0, 3) == 0) button[k] = ~button[k];
      idle($urandom_range(2, 6));
      scan_tick(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NBTN - 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
